alu_stream: RTL and testbench

//  Next-generation ALU with a width parameter and a registered result.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_seq_mul.sv | 55 +++++
 rtl/alu_stream.sv | 129 ++++++++++++
 tb/tb_alu_stream.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared operation codes and controller state type for the streaming ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // done and p are combinational so the caller can capture the product on the final step edge.
  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign p    = acc_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU with valid/ready on both sides, single-cycle ops and a WIDTH-cycle multiply.
module alu_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic               mul_hi;

  logic [SHW-1:0]     s;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_o;
  logic               alu_c;
  logic               alu_v;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == ALU_MUL);
  assign mul_hi    = |mul_p[2*WIDTH-1:WIDTH];

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (i0),
    .b     (i1),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Shifts run one bit wider so the last bit shifted out lands in the extra position.
  always_comb begin
    s     = i1[SHW-1:0];
    sum   = '0;
    shl_w = {1'b0, i0} << s;
    shr_w = {i0, 1'b0} >> s;
    alu_o = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, i0} + {1'b0, i1};
        alu_o = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (i0[WIDTH-1] == i1[WIDTH-1]) && (sum[WIDTH-1] != i0[WIDTH-1]);
      end
      ALU_SUB: begin
        sum   = {1'b0, i0} + {1'b0, ~i1} + 1'b1;
        alu_o = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (i0[WIDTH-1] != i1[WIDTH-1]) && (sum[WIDTH-1] != i0[WIDTH-1]);
      end
      ALU_AND: alu_o = i0 & i1;
      ALU_OR:  alu_o = i0 | i1;
      ALU_XOR: alu_o = i0 ^ i1;
      ALU_SHL: {alu_c, alu_o} = shl_w;
      ALU_SHR: {alu_o, alu_c} = shr_w;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      o         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == ALU_MUL) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              o         <= alu_o;
              cout      <= alu_c;
              ovf       <= alu_v;
              zero      <= (alu_o == '0);
              neg       <= alu_o[WIDTH-1];
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            o         <= mul_p[WIDTH-1:0];
            cout      <= mul_hi;
            ovf       <= mul_hi;
            zero      <= (mul_p[WIDTH-1:0] == '0);
            neg       <= mul_p[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream at WIDTH=16: directed table, corner sequences, random ops.
module tb_alu_stream;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] i0;
  logic [15:0] i1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] o;
  logic        cout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  alu_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .i0        (i0),
    .i1        (i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op; returns {o, cout, zero, neg, ovf}.
  function automatic logic [19:0] model(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, r, s;
    int          sa, sb, sr;
    logic [15:0] res;
    bit          c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    s = b & 32'hf;
    res = '0; c = 0; v = 0; r = 0; sr = 0;
    case (opc)
      ALU_ADD: begin
        r = ua + ub; res = r[15:0]; c = r[16];
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      ALU_SUB: begin
        r = ua + (ub ^ 32'hffff) + 1; res = r[15:0]; c = r[16];
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SHL: begin
        r = ua << s; res = r[15:0];
        c = (s != 0) && (((ua >> (16 - s)) & 1) != 0);
      end
      ALU_SHR: begin
        r = ua >> s; res = r[15:0];
        c = (s != 0) && (((ua >> (s - 1)) & 1) != 0);
      end
      default: begin
        r = ua * ub; res = r[15:0];
        c = (r >> 16) != 0; v = c;
      end
    endcase
    return {res, c, (res == 16'h0), res[15], v};
  endfunction

  // Presents one op, waits for acceptance, then counts edges until out_valid.
  task automatic issue(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic ir_low);
    int n;
    @(negedge clk);
    op = opc; i0 = a; i1 = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); i0 = 16'($urandom); i1 = 16'($urandom);
    lat = 0; ir_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string nm, input logic [2:0] opc, input logic [19:0] exp,
                          input int lat, input logic ir_low);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " latency"}, 32'(lat), (opc == ALU_MUL) ? 32'd16 : 32'd0);
    chk({nm, " o/c/z/n/v"}, {12'h0, o, cout, zero, neg, ovf}, {12'h0, exp});
    if (opc == ALU_MUL) chk({nm, " in_ready low during mul"}, 32'(ir_low), 32'd1);
  endtask

  initial begin
    int          lat;
    logic        ir_low;
    logic        stayed_low;
    logic [15:0] ea, eb, held;
    logic [2:0]  ropc;

    vecs[0]  = '{ALU_ADD, 16'hffff, 16'h0001, 16'h0000, 1, 1, 0, 0};
    vecs[1]  = '{ALU_SUB, 16'h0001, 16'h7fff, 16'h8002, 0, 0, 1, 0};
    vecs[2]  = '{ALU_SUB, 16'h8000, 16'h0001, 16'h7fff, 1, 0, 0, 1};
    vecs[3]  = '{ALU_SHL, 16'haa55, 16'h0001, 16'h54aa, 1, 0, 0, 0};
    vecs[4]  = '{ALU_SHR, 16'h0001, 16'h0001, 16'h0000, 1, 1, 0, 0};
    vecs[5]  = '{ALU_SHL, 16'h1234, 16'h0010, 16'h1234, 0, 0, 0, 0};
    vecs[6]  = '{ALU_MUL, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 1};
    vecs[7]  = '{ALU_MUL, 16'h0003, 16'h0005, 16'h000f, 0, 0, 0, 0};
    vecs[8]  = '{ALU_AND, 16'hf0f0, 16'hff00, 16'hf000, 0, 0, 1, 0};
    vecs[9]  = '{ALU_OR,  16'h0f00, 16'h00f0, 16'h0ff0, 0, 0, 0, 0};
    vecs[10] = '{ALU_XOR, 16'hffff, 16'hffff, 16'h0000, 0, 1, 0, 0};
    vecs[11] = '{ALU_ADD, 16'h7fff, 16'h0001, 16'h8000, 0, 0, 1, 1};
    vecs[12] = '{ALU_SHR, 16'h8000, 16'h000f, 16'h0001, 0, 0, 0, 0};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; i0 = '0; i1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset o/flags", {12'h0, o, cout, zero, neg, ovf}, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, ir_low);
      check_op($sformatf("vec%0d", i), vecs[i].op,
               {vecs[i].o, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v}, lat, ir_low);
    end

    // Back-to-back ADDs with in_valid held high: one result per edge.
    @(negedge clk);
    ea = 16'h1000; eb = 16'h0234;
    op = ALU_ADD; i0 = ea; i1 = eb; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d o", k), 32'(o), 32'(16'(ea + eb)));
      chk($sformatf("b2b%0d in_ready", k), 32'(in_ready), 32'd1);
      ea = ea + 16'h0101; eb = eb ^ 16'h5a5a;
      i0 = ea; i1 = eb;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held while out_ready is low, then released together with a new ADD.
    out_ready = 1'b0;
    issue(ALU_ADD, 16'h1234, 16'h1111, lat, ir_low);
    check_op("bp first", ALU_ADD, model(ALU_ADD, 16'h1234, 16'h1111), lat, ir_low);
    op = ALU_ADD; i0 = 16'h0002; i1 = 16'h0003; in_valid = 1'b1;
    held = o;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp hold%0d valid/o/flags", k), {11'h0, out_valid, o, cout, zero, neg, ovf},
          {11'h0, 1'b1, 16'h2345, 4'b0000});
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp new result", {15'h0, out_valid, o}, {15'h0, 1'b1, 16'h0005});
    chk("bp result changed", 32'(held != o), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp drain out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply discards it.
    op = ALU_MUL; i0 = 16'h0100; i1 = 16'h0100; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid-mul in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("mulrst out_valid", 32'(out_valid), 32'd0);
    chk("mulrst in_ready", 32'(in_ready), 32'd1);
    chk("mulrst o", 32'(o), 32'd0);
    stayed_low = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stayed_low = 1'b0;
    end
    chk("mulrst no late result", 32'(stayed_low), 32'd1);
    issue(ALU_ADD, 16'h0005, 16'h0007, lat, ir_low);
    check_op("post-reset add", ALU_ADD, {16'h000c, 4'b0000}, lat, ir_low);

    // Random ops against the reference model.
    for (int k = 0; k < 300; k++) begin
      ropc = 3'($urandom_range(0, 7));
      ea = 16'($urandom);
      eb = 16'($urandom);
      if (k % 7 == 0) eb = 16'($urandom_range(0, 16));
      issue(ropc, ea, eb, lat, ir_low);
      check_op($sformatf("rand%0d op%0d %h,%h", k, ropc, ea, eb), ropc, model(ropc, ea, eb), lat, ir_low);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
